// File: rtl/conv_mac_controller_pkg.sv
// Shared types and width helpers for the convolution MAC controller.
package conv_mac_controller_pkg;

  // Controller phases: idle, serial weight load, window streaming, pipeline drain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Accumulator width: enough headroom that summing all lanes never overflows.
  function automatic int sum_width(input int data_width, input int lanes);
    return data_width + $clog2(lanes);
  endfunction

  // Width of a lane index; kept at least one bit for the single-lane case.
  function automatic int index_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/conv_mac_controller_lane_adder_tree.sv
// Combinational unsigned reduction of all product lanes into one wide sum.
module lane_adder_tree #(
  parameter int LANES      = 9,
  parameter int DATA_WIDTH = 32,
  parameter int SUM_WIDTH  = 36
) (
  input  logic [LANES*DATA_WIDTH-1:0] lanes,
  output logic [SUM_WIDTH-1:0]        sum
);

  // Zero-extend every lane to the full sum width before adding; synthesis
  // is free to rebalance the chain into a tree.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_WIDTH'(lanes[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule

// File: rtl/conv_mac_controller.sv
// Convolution MAC controller: loads a KxK weight set serially, then streams
// pixel windows through an external lane multiplier and a 3-stage pipeline
// (pixel register, product capture, lane sum) with global backpressure.
module conv_mac_controller
  import conv_mac_controller_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  KERNEL_SIZE = 3,
  localparam int N           = KERNEL_SIZE * KERNEL_SIZE,
  localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, N)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             num_windows,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [N*DATA_WIDTH-1:0] win_data,
  output logic [N*DATA_WIDTH-1:0] mult_weights,
  output logic [N*DATA_WIDTH-1:0] mult_pixels,
  input  logic [N*DATA_WIDTH-1:0] mult_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_WIDTH-1:0]    out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = index_width(N);

  state_t                    state;
  state_t                    state_next;
  logic [15:0]               num_latched;
  logic [15:0]               win_count;
  logic [IDX_W-1:0]          w_idx;
  logic                      s1_valid;
  logic                      s2_valid;
  logic [N*DATA_WIDTH-1:0]   s2_products;
  logic [SUM_WIDTH-1:0]      lane_sum;

  logic advance;
  logic w_fire;
  logic win_fire;
  logic last_weight;
  logic last_window;
  logic drained;

  // The whole pipeline moves only when the output register can be emptied.
  assign advance     = !out_valid || out_ready;
  assign w_ready     = (state == LOAD);
  assign win_ready   = (state == RUN) && advance && (win_count < num_latched);
  assign w_fire      = w_valid && w_ready;
  assign win_fire    = win_valid && win_ready;
  assign last_weight = (w_idx == IDX_W'(N - 1));
  assign last_window = ((win_count + 16'd1) == num_latched);
  assign drained     = !s1_valid && !s2_valid && !out_valid;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_next = state;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  if (w_fire && last_weight)
               state_next = (num_latched == 16'd0) ? FLUSH : RUN;
      RUN:   if (win_fire && last_window) state_next = FLUSH;
      FLUSH: if (drained) begin
               state_next = IDLE;
               done       = 1'b1;
             end
      default: state_next = IDLE;
    endcase
  end

  // Job setup and serial weight load; weights stay put until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_latched  <= '0;
      w_idx        <= '0;
      // NOTE: the weight bank is cleared on reset because it drives an output
      // that must read zero out of reset; plain storage would not need it.
      mult_weights <= '0;
    end else begin
      if (state == IDLE && start) begin
        num_latched <= num_windows;
        w_idx       <= '0;
      end
      if (w_fire) begin
        mult_weights[w_idx*DATA_WIDTH +: DATA_WIDTH] <= w_data;
        w_idx <= last_weight ? '0 : w_idx + IDX_W'(1);
      end
    end
  end

  // Stage 1: register the accepted window onto the multiplier pixel inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      mult_pixels <= '0;
      win_count   <= '0;
    end else if (state == IDLE && start) begin
      win_count <= '0;
    end else if (advance) begin
      s1_valid <= win_fire;
      if (win_fire) begin
        mult_pixels <= win_data;
        win_count   <= win_count + 16'd1;
      end
    end
  end

  // Stage 2: capture the external per-lane products.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid    <= 1'b0;
      s2_products <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_products <= mult_result;
    end
  end

  lane_adder_tree #(
    .LANES      (N),
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_lane_adder_tree (
    .lanes (s2_products),
    .sum   (lane_sum)
  );

  // Stage 3: register the window dot product; holds while the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) out_data <= lane_sum;
    end
  end

endmodule

// File: tb/tb_conv_mac_controller.sv
// Directed, scoreboard-checked bench for conv_mac_controller.
module tb_conv_mac_controller;

  localparam int DW = 32;
  localparam int N  = 9;
  localparam int SW = DW + $clog2(N);

  typedef struct {
    logic [SW-1:0] sum;
    int            cyc;
  } sb_t;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [15:0]     num_windows;
  logic            w_valid;
  logic            w_ready;
  logic [DW-1:0]   w_data;
  logic            win_valid;
  logic            win_ready;
  logic [N*DW-1:0] win_data;
  logic [N*DW-1:0] mult_weights;
  logic [N*DW-1:0] mult_pixels;
  logic [N*DW-1:0] mult_result;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_data;
  logic            busy;
  logic            done;

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              out_count = 0;
  int              done_count = 0;
  bit              check_latency = 0;
  sb_t             sb[$];
  logic [DW-1:0]   wt [N];
  logic [N*DW-1:0] win_tab [8];

  conv_mac_controller #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_windows  (num_windows),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_data     (win_data),
    .mult_weights (mult_weights),
    .mult_pixels  (mult_pixels),
    .mult_result  (mult_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  // External lane multiplier: unsigned products truncated to DW bits.
  for (genvar g = 0; g < N; g++) begin : g_mul
    assign mult_result[g*DW +: DW] = mult_weights[g*DW +: DW] * mult_pixels[g*DW +: DW];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_sum(input logic [N*DW-1:0] win);
    logic [SW-1:0] acc;
    logic [DW-1:0] p;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      p   = wt[i] * win[i*DW +: DW];
      acc = acc + SW'(p);
    end
    return acc;
  endfunction

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [N*DW-1:0] pack_wt();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = wt[i];
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    sb_t e;
    #3;
    if (done) done_count++;
    if (out_valid && out_ready) begin
      out_count++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=out_valid expected=no_output");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.sum);
        if (check_latency) check("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic start_job(input int n);
    start       = 1'b1;
    num_windows = 16'(n);
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_after_start", busy, 1);
  endtask

  task automatic load_weights();
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1;
      w_data  = wt[i];
      #1 check("w_ready", w_ready, 1);
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  // Streams n windows from win_tab, optionally stalling the sink for
  // stall_len cycles once the first result appears, until done.
  task automatic run_windows(input int n, input int stall_len, input bit lat);
    int sent, stall_left, budget, outs0, dones0;
    bit stalled, got_done;
    sent = 0; stall_left = 0; budget = 0; stalled = 0; got_done = 0;
    outs0 = out_count; dones0 = done_count; check_latency = lat;
    while (!got_done && budget < 200) begin
      win_valid = (sent < n);
      if (sent < n) win_data = win_tab[sent];
      out_ready = (stall_left == 0);
      #1;
      if (!stalled && stall_len > 0 && out_valid) begin
        stalled    = 1;
        stall_left = stall_len;
        out_ready  = 1'b0;
        #1;
      end
      if (stall_left > 0) begin
        check("stall_win_ready", win_ready, 0);
        if (sb.size() > 0) check("stall_hold", out_data, sb[0].sum);
      end else if (sent < n) begin
        check("win_ready", win_ready, 1);
      end
      if (n == 0) check("no_win_ready", win_ready, 0);
      if (win_valid && win_ready) begin
        sb.push_back('{sum: model_sum(win_tab[sent]), cyc: cyc});
        sent++;
      end
      got_done = done;
      @(negedge clk);
      budget++;
      if (stall_left > 0) stall_left--;
    end
    win_valid = 1'b0;
    out_ready = 1'b1;
    check("done_seen", got_done, 1);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("done_count", done_count - dones0, 1);
    check("out_count", out_count - outs0, n);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; num_windows = '0;
    w_valid = 1'b0; w_data = '0; win_valid = 1'b0; win_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_win_ready", win_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_mult_weights", mult_weights, 0);
    check("rst_mult_pixels", mult_pixels, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Weights 1..9, one window of all 2 -> 90.
    for (int i = 0; i < N; i++) wt[i] = DW'(i + 1);
    win_tab[0] = fill(32'd2);
    start_job(1);
    load_weights();
    check("r29_weights", mult_weights, pack_wt());
    run_windows(1, 0, 1);
    check("r29_out_data", out_data, 90);
    check("r29_weights_stable", mult_weights, pack_wt());

    // Four windows back to back, unit weights -> 9, 18, 27, 36.
    for (int i = 0; i < N; i++) wt[i] = 32'd1;
    for (int k = 0; k < 4; k++) win_tab[k] = fill(DW'(k + 1));
    start_job(4);
    load_weights();
    run_windows(4, 0, 1);
    check("r30_last_out", out_data, 36);

    // Same job with a 5-cycle sink stall after the first result.
    start_job(4);
    load_weights();
    run_windows(4, 5, 0);
    check("r31_last_out", out_data, 36);

    // Zero-window job: weights load, no window accepted, single done.
    start_job(0);
    load_weights();
    run_windows(0, 0, 1);

    // All-ones operands: each lane product wraps to 1.
    for (int i = 0; i < N; i++) wt[i] = 32'hFFFF_FFFF;
    win_tab[0] = fill(32'hFFFF_FFFF);
    start_job(1);
    load_weights();
    check("r33_weights", mult_weights, pack_wt());
    run_windows(1, 0, 1);
    check("r33_out_data", out_data, 9);

    // Reset during the second of four windows, then a fresh job.
    for (int i = 0; i < N; i++) wt[i] = 32'd1;
    for (int k = 0; k < 4; k++) win_tab[k] = fill(DW'(k + 1));
    start_job(4);
    load_weights();
    win_valid = 1'b1;
    win_data  = win_tab[0];
    @(negedge clk);
    win_data = win_tab[1];
    #1;
    reset_n = 1'b0;
    #1;
    check("r34_busy", busy, 0);
    check("r34_win_ready", win_ready, 0);
    check("r34_out_valid", out_valid, 0);
    check("r34_done", done, 0);
    check("r34_mult_weights", mult_weights, 0);
    check("r34_mult_pixels", mult_pixels, 0);
    win_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("r34_idle_after_reset", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("r34_no_stray_valid", out_valid, 0);
    end
    start_job(4);
    load_weights();
    run_windows(4, 0, 1);
    check("r34_last_out", out_data, 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a directed step never completes.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
